// File: rtl/copro_issue_ctrl_if.sv
// Handshake bundle between the LM32 user-instruction port, the issue
// controller and the downstream float arithmetic unit.
// slave: controller view. master: LM32 side plus arithmetic-unit stub.
interface copro_issue_ctrl_if #(
    parameter int NE = 8,
    parameter int NM = 23
);
    logic              start;
    logic [2:0]        opcode;
    logic [31:0]       dataa;
    logic [31:0]       datab;
    logic              busy;
    logic              done;
    logic [31:0]       result;
    logic              err;
    logic              op_valid;
    logic [1:0]        op_code;
    logic [NE+NM:0]    op_a;
    logic [NE+NM:0]    op_b;
    logic              res_valid;
    logic [NE+NM:0]    res_in;

    modport slave (
        input  start, opcode, dataa, datab, res_valid, res_in,
        output busy, done, result, err, op_valid, op_code, op_a, op_b
    );

    modport master (
        output start, opcode, dataa, datab, res_valid, res_in,
        input  busy, done, result, err, op_valid, op_code, op_a, op_b
    );
endinterface

// File: rtl/copro_issue_ctrl.sv
// Sequential front-end: converts one IEEE single-precision instruction into
// the internal {s,exp,mant} float format, issues it to the arithmetic unit,
// waits (bounded) for the result and converts it back to IEEE.
module copro_issue_ctrl #(
    parameter int NM      = 23,
    parameter int NE      = 8,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    copro_issue_ctrl_if.slave  bus
);
    localparam int W    = NE + NM + 1;
    localparam int BIAS = (1 << (NE - 1)) - 1;
    // Exponent arithmetic is done wide enough for both the IEEE range and
    // the internal range, so e_ieee=254 cannot wrap for small NE.
    localparam int EW   = ((NE > 8) ? NE : 8) + 2;
    localparam int CW   = $clog2(TIMEOUT + 1);

    localparam logic signed [EW-1:0] EOFF  = EW'(BIAS - 127);
    localparam logic signed [EW-1:0] EMAXI = EW'((1 << NE) - 1);
    localparam logic signed [EW-1:0] EMAXF = EW'(255);

    typedef enum logic [2:0] {
        S_IDLE, S_CONV, S_ISSUE, S_WAIT, S_PACK, S_DONE
    } state_t;

    state_t         state, state_next;
    logic [1:0]     opc_q;
    logic [31:0]    a_q, b_q;
    logic [W-1:0]   res_q;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_inc;
    logic           timeout_hit;
    logic [31:0]    result_q;
    logic           err_q;
    logic [1:0]     op_code_q;
    logic [W-1:0]   op_a_q, op_b_q;

    function automatic logic [W-1:0] to_int(input logic [31:0] f);
        logic signed [EW-1:0] e;
        logic [W-1:0]         r;
        e = $signed({{(EW-8){1'b0}}, f[30:23]}) + EOFF;
        r = '0;
        r[W-1] = f[31];
        if (f[30:23] == 8'hFF || e >= EMAXI) begin
            r[NE+NM-1:NM] = '1;
        end else if (f[30:23] != 8'h00 && e > 0) begin
            r[NE+NM-1:NM] = e[NE-1:0];
            r[NM-1:0]     = f[22 -: NM];
        end
        return r;
    endfunction

    function automatic logic [31:0] to_ieee(input logic [W-1:0] r);
        logic signed [EW-1:0] e;
        logic [NE-1:0]        ex;
        logic [22:0]          m;
        logic [31:0]          f;
        ex = r[NE+NM-1:NM];
        e  = $signed({{(EW-NE){1'b0}}, ex}) - EOFF;
        m  = '0;
        m[22 -: NM] = r[NM-1:0];
        f  = {r[W-1], 31'b0};
        if (ex == '1 || e >= EMAXF) begin
            f = {r[W-1], 8'hFF, 23'b0};
        end else if (ex != '0 && e > 0) begin
            f = {r[W-1], e[7:0], m};
        end
        return f;
    endfunction

    assign cnt_inc     = cnt + 1'b1;
    assign timeout_hit = (cnt_inc == CW'(TIMEOUT));

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    // Next-state decode and Moore strobes
    always_comb begin
        state_next   = state;
        bus.busy     = (state != S_IDLE);
        bus.done     = (state == S_DONE);
        bus.op_valid = (state == S_ISSUE);
        case (state)
            S_IDLE:  if (bus.start) state_next = bus.opcode[2] ? S_DONE : S_CONV;
            S_CONV:  state_next = S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT: begin
                if (bus.res_valid)     state_next = S_PACK;
                else if (timeout_hit)  state_next = S_DONE;
            end
            S_PACK:  state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Operand latching, conversion, timeout counting and result capture
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            opc_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            cnt       <= '0;
            result_q  <= '0;
            err_q     <= 1'b0;
            op_code_q <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.opcode[2]) begin
                            result_q <= '0;
                            err_q    <= 1'b1;
                        end else begin
                            a_q   <= bus.dataa;
                            b_q   <= bus.datab;
                            opc_q <= bus.opcode[1:0];
                        end
                    end
                end
                S_CONV: begin
                    op_a_q    <= to_int(a_q);
                    op_b_q    <= to_int(b_q);
                    op_code_q <= opc_q;
                end
                S_ISSUE: cnt <= '0;
                S_WAIT: begin
                    if (bus.res_valid) begin
                        res_q <= bus.res_in;
                    end else begin
                        cnt <= cnt_inc;
                        if (timeout_hit) begin
                            result_q <= 32'h7FC0_0000;
                            err_q    <= 1'b1;
                        end
                    end
                end
                S_PACK: begin
                    result_q <= to_ieee(res_q);
                    err_q    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.result  = result_q;
    assign bus.err     = err_q;
    assign bus.op_code = op_code_q;
    assign bus.op_a    = op_a_q;
    assign bus.op_b    = op_b_q;
endmodule

// File: tb/tb_copro_issue_ctrl.sv
// Directed bench for copro_issue_ctrl: default format (NE=8, NM=23) on dut_a,
// reduced format (NE=6, NM=10) on dut_b for the conversion rules.
module tb_copro_issue_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   ov_cnt = 0;
    int   dn_cnt = 0;

    copro_issue_ctrl_if #(.NE(8), .NM(23)) ifa ();
    copro_issue_ctrl_if #(.NE(6), .NM(10)) ifb ();

    copro_issue_ctrl #(.NM(23), .NE(8), .TIMEOUT(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(ifa)
    );
    copro_issue_ctrl #(.NM(10), .NE(6), .TIMEOUT(16)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(ifb)
    );

    always #5 clk = ~clk;

    // Pulse counters for dut_a issue and completion strobes
    always @(posedge clk) begin
        if (ifa.op_valid) ov_cnt++;
        if (ifa.done)     dn_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        step();
        checks++;
        if ({ifa.busy, ifa.done, ifa.err, ifa.op_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000", {ifa.busy, ifa.done, ifa.err, ifa.op_valid});
        end
        checks++;
        if ({ifa.result, ifa.op_code, ifa.op_a, ifa.op_b} !== '0) begin
            errors++;
            $display("FAIL reset_data: result=%h op_code=%0d op_a=%h op_b=%h expected all 0",
                     ifa.result, ifa.op_code, ifa.op_a, ifa.op_b);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_mul();
        ifa.start = 1'b1; ifa.opcode = 3'd0;
        ifa.dataa = 32'h4000_0000; ifa.datab = 32'h4040_0000;
        step();                                  // cycle 1: CONV
        ifa.start = 1'b0;
        checks++;
        if (ifa.busy !== 1'b1 || ifa.op_valid !== 1'b0) begin
            errors++;
            $display("FAIL mul_conv: busy=%b op_valid=%b expected 1 0", ifa.busy, ifa.op_valid);
        end
        step();                                  // cycle 2: ISSUE
        checks++;
        if (ifa.op_valid !== 1'b1) begin
            errors++;
            $display("FAIL mul_issue: op_valid=%b expected 1", ifa.op_valid);
        end
        checks++;
        if (ifa.op_a !== 32'h4000_0000 || ifa.op_b !== 32'h4040_0000 || ifa.op_code !== 2'd0) begin
            errors++;
            $display("FAIL mul_operands: op_a=%h op_b=%h op_code=%0d expected 40000000 40400000 0",
                     ifa.op_a, ifa.op_b, ifa.op_code);
        end
        step();                                  // cycle 3: WAIT
        ifa.res_valid = 1'b1; ifa.res_in = 32'h40C0_0000;
        step();                                  // cycle 4: PACK
        ifa.res_valid = 1'b0;
        checks++;
        if (ifa.done !== 1'b0 || ifa.op_valid !== 1'b0) begin
            errors++;
            $display("FAIL mul_pack: done=%b op_valid=%b expected 0 0", ifa.done, ifa.op_valid);
        end
        step();                                  // cycle 5: DONE
        checks++;
        if (ifa.done !== 1'b1 || ifa.result !== 32'h40C0_0000 || ifa.err !== 1'b0) begin
            errors++;
            $display("FAIL mul_done: done=%b result=%h err=%b expected 1 40c00000 0",
                     ifa.done, ifa.result, ifa.err);
        end
        step();
        checks++;
        if (ifa.done !== 1'b0 || ifa.busy !== 1'b0 || ifa.result !== 32'h40C0_0000) begin
            errors++;
            $display("FAIL mul_after: done=%b busy=%b result=%h expected 0 0 40c00000",
                     ifa.done, ifa.busy, ifa.result);
        end
    endtask

    task automatic test_illegal();
        int ov0;
        ov0 = ov_cnt;
        ifa.start = 1'b1; ifa.opcode = 3'd5;
        step();
        ifa.start = 1'b0;
        checks++;
        if (ifa.done !== 1'b1 || ifa.result !== 32'h0 || ifa.err !== 1'b1) begin
            errors++;
            $display("FAIL illegal_done: done=%b result=%h err=%b expected 1 00000000 1",
                     ifa.done, ifa.result, ifa.err);
        end
        step();
        checks++;
        if (ifa.busy !== 1'b0 || ifa.done !== 1'b0 || ov_cnt != ov0) begin
            errors++;
            $display("FAIL illegal_after: busy=%b done=%b op_valid pulses=%0d expected 0 0 0",
                     ifa.busy, ifa.done, ov_cnt - ov0);
        end
    endtask

    task automatic test_timeout();
        int cyc;
        bit busy_ok;
        ifa.start = 1'b1; ifa.opcode = 3'd2;
        ifa.dataa = 32'h3F80_0000; ifa.datab = 32'h3F80_0000;
        step();
        ifa.start = 1'b0;
        cyc = 1;
        busy_ok = 1'b1;
        while (ifa.done !== 1'b1 && cyc < 40) begin
            if (ifa.busy !== 1'b1) busy_ok = 1'b0;
            step();
            cyc++;
        end
        checks++;
        if (cyc != 19) begin
            errors++;
            $display("FAIL timeout_latency: done after %0d cycles expected 19", cyc);
        end
        checks++;
        if (!busy_ok || ifa.busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_busy: busy dropped before done (busy=%b) expected held 1", ifa.busy);
        end
        checks++;
        if (ifa.result !== 32'h7FC0_0000 || ifa.err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_result: result=%h err=%b expected 7fc00000 1", ifa.result, ifa.err);
        end
        step();
    endtask

    task automatic test_timeout_edge();
        ifa.start = 1'b1; ifa.opcode = 3'd3;
        step();
        ifa.start = 1'b0;
        for (int c = 1; c < 18; c++) step();     // now cycle 18, last WAIT cycle
        ifa.res_valid = 1'b1; ifa.res_in = 32'h3F80_0000;
        step();
        ifa.res_valid = 1'b0;
        checks++;
        if (ifa.done !== 1'b0 || ifa.busy !== 1'b1) begin
            errors++;
            $display("FAIL edge_pack: done=%b busy=%b expected 0 1", ifa.done, ifa.busy);
        end
        step();
        checks++;
        if (ifa.done !== 1'b1 || ifa.result !== 32'h3F80_0000 || ifa.err !== 1'b0) begin
            errors++;
            $display("FAIL edge_done: done=%b result=%h err=%b expected 1 3f800000 0",
                     ifa.done, ifa.result, ifa.err);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int ov0, dn0;
        ov0 = ov_cnt; dn0 = dn_cnt;
        ifa.start = 1'b1; ifa.opcode = 3'd0;
        ifa.dataa = 32'h3F80_0000; ifa.datab = 32'h4080_0000;
        step();
        ifa.start = 1'b0;
        step();
        step();                                  // cycle 3: WAIT
        ifa.start = 1'b1; ifa.opcode = 3'd2; ifa.dataa = 32'h4100_0000;
        step();
        ifa.start = 1'b0;
        ifa.res_valid = 1'b1; ifa.res_in = 32'h4100_0000;
        step();
        ifa.res_valid = 1'b0;
        step();
        checks++;
        if (ifa.done !== 1'b1 || ifa.result !== 32'h4100_0000 || ifa.err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done: done=%b result=%h err=%b expected 1 41000000 0",
                     ifa.done, ifa.result, ifa.err);
        end
        checks++;
        if (ifa.op_a !== 32'h3F80_0000 || ifa.op_code !== 2'd0) begin
            errors++;
            $display("FAIL b2b_operands: op_a=%h op_code=%0d expected 3f800000 0", ifa.op_a, ifa.op_code);
        end
        for (int c = 0; c < 5; c++) step();
        checks++;
        if (ov_cnt - ov0 != 1 || dn_cnt - dn0 != 1 || ifa.busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_counts: op_valid=%0d done=%0d busy=%b expected 1 1 0",
                     ov_cnt - ov0, dn_cnt - dn0, ifa.busy);
        end
    endtask

    task automatic test_reset_mid();
        int dn0;
        bit quiet;
        dn0 = dn_cnt;
        ifa.start = 1'b1; ifa.opcode = 3'd3;
        ifa.dataa = 32'h4000_0000; ifa.datab = 32'h3F80_0000;
        step();
        ifa.start = 1'b0;
        step();
        step();                                  // cycle 3: WAIT
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        ifa.res_valid = 1'b1; ifa.res_in = 32'h40C0_0000;
        step();
        ifa.res_valid = 1'b0;
        quiet = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (ifa.busy !== 1'b0 || ifa.done !== 1'b0 || ifa.op_valid !== 1'b0) quiet = 1'b0;
            step();
        end
        checks++;
        if (!quiet || dn_cnt != dn0) begin
            errors++;
            $display("FAIL rstmid_quiet: busy/done/op_valid activity after reset, done pulses=%0d expected 0",
                     dn_cnt - dn0);
        end
        checks++;
        if ({ifa.result, ifa.err, ifa.op_code, ifa.op_a, ifa.op_b} !== '0) begin
            errors++;
            $display("FAIL rstmid_data: result=%h err=%b op_code=%0d op_a=%h op_b=%h expected all 0",
                     ifa.result, ifa.err, ifa.op_code, ifa.op_a, ifa.op_b);
        end
    endtask

    task automatic test_conv();
        logic [31:0] va [3];
        logic [31:0] vb [3];
        logic [16:0] ea [3];
        logic [16:0] eb [3];
        logic [16:0] rin [3];
        logic [31:0] er [3];
        va[0] = 32'h3FC0_0000; vb[0] = 32'h7F00_0000;
        ea[0] = {1'b0, 6'd31, 10'h200}; eb[0] = {1'b0, 6'h3F, 10'h000};
        rin[0] = {1'b1, 6'd32, 10'h100}; er[0] = 32'hC020_0000;
        va[1] = 32'h0040_0000; vb[1] = 32'hFF80_0000;
        ea[1] = 17'h0; eb[1] = {1'b1, 6'h3F, 10'h000};
        rin[1] = {1'b0, 6'h3F, 10'h155}; er[1] = 32'h7F80_0000;
        va[2] = 32'h3000_0000; vb[2] = 32'h3080_0000;
        ea[2] = 17'h0; eb[2] = {1'b0, 6'd1, 10'h000};
        rin[2] = {1'b0, 6'd0, 10'h3FF}; er[2] = 32'h0;
        for (int i = 0; i < 3; i++) begin
            ifb.start = 1'b1; ifb.opcode = 3'(i + 1);
            ifb.dataa = va[i]; ifb.datab = vb[i];
            step();
            ifb.start = 1'b0;
            step();                              // ISSUE
            checks++;
            if (ifb.op_a !== ea[i] || ifb.op_b !== eb[i] || ifb.op_code !== 2'(i + 1)) begin
                errors++;
                $display("FAIL conv_in[%0d]: op_a=%h op_b=%h op_code=%0d expected %h %h %0d",
                         i, ifb.op_a, ifb.op_b, ifb.op_code, ea[i], eb[i], i + 1);
            end
            step();
            ifb.res_valid = 1'b1; ifb.res_in = rin[i];
            step();
            ifb.res_valid = 1'b0;
            step();
            checks++;
            if (ifb.done !== 1'b1 || ifb.result !== er[i] || ifb.err !== 1'b0) begin
                errors++;
                $display("FAIL conv_out[%0d]: done=%b result=%h err=%b expected 1 %h 0",
                         i, ifb.done, ifb.result, ifb.err, er[i]);
            end
            step();
        end
    endtask

    initial begin
        ifa.start = 1'b0; ifa.opcode = '0; ifa.dataa = '0; ifa.datab = '0;
        ifa.res_valid = 1'b0; ifa.res_in = '0;
        ifb.start = 1'b0; ifb.opcode = '0; ifb.dataa = '0; ifb.datab = '0;
        ifb.res_valid = 1'b0; ifb.res_in = '0;
        #1;
        test_reset();
        test_mul();
        test_illegal();
        test_timeout();
        test_timeout_edge();
        test_back_to_back();
        test_reset_mid();
        test_conv();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
